joy_scan_ctrl: RTL and testbench

Scan sequencer for the serial joystick shift-register chain (parallel-load, serial-out) on the joystick add-on connector. It generates the chain's load and shift clock at a parameterised rate, captures an NBITS-bit frame, double-buffers it, and exposes the two 6-bit joystick states to the MSX core. Scans run periodically in auto mode or on explicit request through a req/busy handshake.

---
 rtl/joy_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_joy_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_scan_ctrl.sv
// Joystick chain scan sequencer: load/shift clocking, frame capture,
// double buffering and change detection for the two 6-bit joysticks.
module joy_scan_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int NBITS     = 12,
    parameter int GAP_TICKS = 64
) (
    input  logic             clk,
    input  logic             clock_locked,
    input  logic             joy_data,
    output logic             joy_clk,
    output logic             joy_load,
    input  logic             auto_en,
    input  logic             scan_req,
    output logic             scan_busy,
    output logic [NBITS-1:0] frame,
    output logic             frame_valid,
    output logic             frame_changed,
    output logic [5:0]       joy1,
    output logic [5:0]       joy2
);
    localparam int KW = $clog2(NBITS);
    localparam logic [KW-1:0] K_LAST   = KW'(NBITS - 1);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0]   GAP_MIN  = 16'(GAP_TICKS);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       div_q;
    logic [1:0]       sync_q;
    logic             load_q, load_d;
    logic             jclk_q, jclk_d;
    logic [KW-1:0]    k_q, k_d;
    logic [15:0]      gap_q, gap_d;
    logic             pend_q, pend_d;
    logic [NBITS-1:0] shadow_q, shadow_d;
    logic [NBITS-1:0] frame_q, frame_d;
    logic             valid_q, valid_d;
    logic             chg_q, chg_d;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge clock_locked) begin
        if (!clock_locked) begin
            state_q  <= IDLE;
            div_q    <= '0;
            sync_q   <= '1;
            load_q   <= 1'b1;
            jclk_q   <= 1'b0;
            k_q      <= '0;
            gap_q    <= '0;
            pend_q   <= 1'b0;
            shadow_q <= '1;
            frame_q  <= '1;
            valid_q  <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= tick ? 8'd0 : div_q + 8'd1;
            sync_q   <= {sync_q[0], joy_data};
            load_q   <= load_d;
            jclk_q   <= jclk_d;
            k_q      <= k_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            chg_q    <= chg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        jclk_d   = jclk_q;
        k_d      = k_q;
        gap_d    = gap_q;
        pend_d   = pend_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        valid_d  = 1'b0;
        chg_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    if (pend_q || (auto_en && gap_q >= GAP_MIN)) begin
                        state_d = LOAD;
                        load_d  = 1'b0;
                        pend_d  = 1'b0;
                        gap_d   = '0;
                    end else if (gap_q != 16'hFFFF) begin
                        gap_d = gap_q + 16'd1;
                    end
                end
            end
            LOAD: begin
                if (tick) begin
                    state_d = SHIFT;
                    load_d  = 1'b1;
                    k_d     = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!jclk_q) begin
                        shadow_d[K_LAST - k_q] = sync_q[1];
                        if (k_q == K_LAST) state_d = DONE;
                        else jclk_d = 1'b1;
                    end else begin
                        jclk_d = 1'b0;
                        k_d    = k_q + KW'(1);
                    end
                end
            end
            DONE: begin
                frame_d = shadow_q;
                valid_d = 1'b1;
                chg_d   = (shadow_q != frame_q);
                gap_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a request arriving on the launch clk is kept for a later scan
        if (scan_req) pend_d = 1'b1;
    end

    assign joy_clk       = jclk_q;
    assign joy_load      = load_q;
    assign scan_busy     = (state_q != IDLE);
    assign frame         = frame_q;
    assign frame_valid   = valid_q;
    assign frame_changed = chg_q;

    if (NBITS >= 12) begin : g_joy
        assign joy1 = frame_q[NBITS-1 -: 6];
        assign joy2 = frame_q[NBITS-7 -: 6];
    end else begin : g_nojoy
        assign joy1 = '1;
        assign joy2 = '1;
    end

endmodule

// File: tb/tb_joy_scan_ctrl.sv
// Bench for joy_scan_ctrl: chain model plus a frame-level reference
// model checked with immediate assertions along a directed sequence.
module tb_joy_scan_ctrl;
    localparam int D  = 4;
    localparam int NB = 12;
    localparam int G  = 64;

    logic          clk = 1'b0;
    logic          clock_locked = 1'b0;
    logic          joy_data;
    logic          auto_en = 1'b0;
    logic          scan_req = 1'b0;
    logic          joy_clk, joy_load, scan_busy;
    logic          frame_valid, frame_changed;
    logic [NB-1:0] frame;
    logic [5:0]    joy1, joy2;

    logic [NB-1:0] buttons = 12'hB38;
    logic [NB-1:0] chain = '1;
    logic [NB-1:0] exp_frame = '1;
    logic          chain_jclk = 1'b0;
    logic          busy_prev = 1'b0;
    logic          jclk_prev = 1'b0;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_load = 0;
    int n_rise = 0;
    int n_high = 0;
    int n_fv = 0;
    int fv_cyc = 0;
    int fv_prev = 0;
    int busy_cyc = 0;
    int req_cyc, f0, r0, fv1;

    always #5 clk = ~clk;

    joy_scan_ctrl #(.CLK_DIV(D), .NBITS(NB), .GAP_TICKS(G)) dut (
        .clk(clk), .clock_locked(clock_locked), .joy_data(joy_data),
        .joy_clk(joy_clk), .joy_load(joy_load), .auto_en(auto_en),
        .scan_req(scan_req), .scan_busy(scan_busy), .frame(frame),
        .frame_valid(frame_valid), .frame_changed(frame_changed),
        .joy1(joy1), .joy2(joy2)
    );

    // parallel-load / serial-out chain, MSB (joy1 fire2) first
    assign joy_data = chain[NB-1];
    always @(negedge clk) begin
        if (!joy_load) chain <= buttons;
        else if (joy_clk && !chain_jclk) chain <= {chain[NB-2:0], 1'b1};
        chain_jclk <= joy_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (!joy_load) n_load++;
        if (joy_clk) n_high++;
        if (joy_clk && !jclk_prev) n_rise++;
        jclk_prev = joy_clk;
        if (scan_busy && !busy_prev) busy_cyc = cyc;
        busy_prev = scan_busy;
        if (frame_changed) check("chg_with_valid", 32'(frame_valid), 32'd1);
        if (frame_valid) begin
            n_fv++;
            fv_prev = fv_cyc;
            fv_cyc = cyc;
        end
    endtask

    task automatic pulse_req();
        scan_req = 1'b1;
        step();
        scan_req = 1'b0;
    endtask

    task automatic wait_fv(input string tag, input int budget);
        int f = n_fv;
        int c = 0;
        while (n_fv == f && c < budget) begin
            step();
            c++;
        end
        check({tag, "_fv_seen"}, 32'(n_fv > f), 32'd1);
    endtask

    task automatic wait_busy(input string tag, input int budget);
        int c = 0;
        while (!scan_busy && c < budget) begin
            step();
            c++;
        end
        check({tag, "_busy_seen"}, 32'(scan_busy), 32'd1);
    endtask

    task automatic wait_rises(input string tag, input int target);
        int c = 0;
        while (n_rise < target && c < 400) begin
            step();
            c++;
        end
        check({tag, "_rises_seen"}, 32'(n_rise >= target), 32'd1);
    endtask

    // frame-level reference: a scan returns the buttons held on the chain
    task automatic on_frame(input string tag);
        check({tag, "_frame"}, 32'(frame), 32'(buttons));
        check({tag, "_changed"}, 32'(frame_changed), 32'(buttons != exp_frame));
        check({tag, "_joy1"}, 32'(joy1), 32'(buttons) >> 6);
        check({tag, "_joy2"}, 32'(joy2), 32'(buttons) & 32'h3F);
        exp_frame = buttons;
    endtask

    initial begin
        repeat (3) step();
        check("rst_load", 32'(joy_load), 32'd1);
        check("rst_jclk", 32'(joy_clk), 32'd0);
        check("rst_busy", 32'(scan_busy), 32'd0);
        check("rst_frame", 32'(frame), 32'hFFF);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_changed", 32'(frame_changed), 32'd0);
        check("rst_joy1", 32'(joy1), 32'h3F);
        check("rst_joy2", 32'(joy2), 32'h3F);

        clock_locked = 1'b1;
        repeat (60) step();
        check("no_scan_idle", 32'(n_fv), 32'd0);

        // single request with the reference pattern
        n_load = 0; n_rise = 0; n_high = 0; f0 = n_fv;
        req_cyc = cyc;
        pulse_req();
        wait_fv("t1", 300);
        check("t1_latency", 32'((busy_cyc - req_cyc) >= 1 &&
                                (busy_cyc - req_cyc) <= D + 1), 32'd1);
        check("t1_duration", 32'(fv_cyc - busy_cyc), 32'(2 * NB * D + 1));
        check("t1_load_clks", 32'(n_load), 32'(D));
        check("t1_jclk_rises", 32'(n_rise), 32'(NB - 1));
        check("t1_jclk_high", 32'(n_high), 32'((NB - 1) * D));
        on_frame("t1");
        check("t1_joy1_lit", 32'(joy1), 32'b101100);
        check("t1_joy2_lit", 32'(joy2), 32'b111000);
        repeat (50) step();
        check("t1_one_valid", 32'(n_fv - f0), 32'd1);
        check("t1_idle", 32'(scan_busy), 32'd0);

        // requests with random button patterns (first repeats the data)
        for (int i = 0; i < 4; i++) begin
            if (i != 0) buttons = NB'($urandom);
            pulse_req();
            wait_fv("rnd", 300);
            on_frame("rnd");
            repeat (20) step();
        end

        // periodic scanning
        buttons = NB'($urandom) | 12'h001;
        auto_en = 1'b1;
        wait_fv("auto0", 500);
        on_frame("auto0");
        wait_fv("auto1", 500);
        on_frame("auto1");
        check("auto_period", 32'(fv_cyc - fv_prev), 32'((2 * NB + 1 + G) * D));
        check("auto_same_chg", 32'(frame_changed), 32'd0);
        buttons[0] = 1'b0;
        wait_fv("auto2", 500);
        on_frame("auto2");
        check("auto2_period", 32'(fv_cyc - fv_prev), 32'((2 * NB + 1 + G) * D));
        check("auto2_chg", 32'(frame_changed), 32'd1);
        check("auto2_bit0", 32'(frame[0]), 32'd0);

        // auto_en dropped mid-scan at bit 5
        buttons = NB'($urandom);
        wait_busy("drop", 400);
        r0 = n_rise;
        wait_rises("drop", r0 + 5);
        auto_en = 1'b0;
        f0 = n_fv;
        wait_fv("drop", 200);
        on_frame("drop");
        repeat (800) step();
        check("drop_one_valid", 32'(n_fv - f0), 32'd1);
        check("drop_idle", 32'(scan_busy), 32'd0);

        // requests during SHIFT: exactly one follow-up scan
        buttons = NB'($urandom);
        f0 = n_fv;
        pulse_req();
        wait_busy("mid", 20);
        r0 = n_rise;
        wait_rises("mid", r0 + 3);
        pulse_req();
        wait_rises("mid", r0 + 6);
        pulse_req();
        wait_fv("mid_a", 200);
        on_frame("mid_a");
        fv1 = fv_cyc;
        wait_fv("mid_b", 300);
        on_frame("mid_b");
        check("mid_restart", 32'(fv_cyc - fv1), 32'((2 * NB + 1) * D));
        repeat (500) step();
        check("mid_two_scans", 32'(n_fv - f0), 32'd2);

        // reset at bit 7 aborts the scan
        buttons = NB'($urandom) & 12'hFFE;
        pulse_req();
        wait_busy("arst", 20);
        r0 = n_rise;
        wait_rises("arst", r0 + 7);
        clock_locked = 1'b0;
        #1;
        check("arst_load", 32'(joy_load), 32'd1);
        check("arst_jclk", 32'(joy_clk), 32'd0);
        check("arst_busy", 32'(scan_busy), 32'd0);
        check("arst_frame", 32'(frame), 32'hFFF);
        exp_frame = '1;
        repeat (3) step();
        clock_locked = 1'b1;
        repeat (2) step();
        n_load = 0; n_rise = 0; f0 = n_fv;
        pulse_req();
        wait_fv("post", 300);
        on_frame("post");
        check("post_load_clks", 32'(n_load), 32'(D));
        check("post_rises", 32'(n_rise), 32'(NB - 1));
        check("post_one_valid", 32'(n_fv - f0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
